// File: rtl/imm_ext_if.sv
// Decode-side bus for imm_ext_pipe: instruction/format in, immediate out, both valid/ready.
interface imm_ext_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       imm_src;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm;
    logic             imm_illegal;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, imm, imm_illegal, err_cnt
    );

    modport slave (
        input  in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, imm, imm_illegal, err_cnt
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// RV32I/RV64I immediate generator behind a 2-entry skid FIFO, with a saturating illegal-format counter.
// Define IMM_ZICSR_EN to decode imm_src 101 as the zero-extended CSR uimm (instr[19:15]).
module imm_ext_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    imm_ext_if.slave  bus
);
    logic [31:0]      w_imm32;
    logic             w_ill;
    logic [XLEN-1:0]  w_imm;
    logic             w_push;
    logic             w_pop;

    logic [1:0]       r_cnt;
    logic             r_wptr;
    logic             r_rptr;
    logic [CNT_W-1:0] r_err;
    logic [XLEN-1:0]  r_imm [2];
    logic             r_ill [2];

    always_comb begin
        w_imm32 = '0;
        w_ill   = 1'b0;
        case (bus.imm_src)
            3'b000: w_imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
            3'b001: w_imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            3'b010: w_imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                               bus.instr[30:25], bus.instr[11:8], 1'b0};
            3'b011: w_imm32 = {bus.instr[31:12], 12'b0};
            3'b100: w_imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                               bus.instr[20], bus.instr[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
            3'b101: w_imm32 = {27'b0, bus.instr[19:15]};
`else
            3'b101: w_ill   = 1'b1;
`endif
            default: w_ill  = 1'b1;
        endcase
    end

    // Z-type has bit 31 clear, so one sign-extension covers every legal format.
    assign w_imm  = w_ill ? '0 : XLEN'($signed(w_imm32));

    assign bus.in_ready    = (r_cnt != 2'd2);
    assign bus.out_valid   = (r_cnt != 2'd0);
    assign bus.imm         = bus.out_valid ? r_imm[r_rptr] : '0;
    assign bus.imm_illegal = bus.out_valid ? r_ill[r_rptr] : 1'b0;
    assign bus.err_cnt     = r_err;

    assign w_push = bus.in_valid  && bus.in_ready;
    assign w_pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_err  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
                if (w_ill && (r_err != '1))
                    r_err <= r_err + 1'b1;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Payload needs no reset: it is only observable through out_valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_imm[r_wptr] <= w_imm;
            r_ill[r_wptr] <= w_ill;
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe (XLEN=64, CNT_W=2): queue-based reference model, randomized traffic.
module tb_imm_ext_pipe;
    localparam int XLEN  = 64;
    localparam int CNT_W = 2;

    typedef struct {
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_ext_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
    imm_ext_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    exp_t q[$];
    exp_t pend_e;
    logic pend    = 1'b0;
    int   m_err   = 0;
    logic mon_en  = 1'b0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: immediate as a signed integer assembled from the field positions.
    function automatic exp_t ref_imm(logic [31:0] ins, logic [2:0] src);
        exp_t   e;
        longint s;
        longint v;
        s = longint'($signed(ins)) >>> 31;   // 0 or -1
        e.ill = 1'b0;
        v = 0;
        case (src)
            3'd0: v = longint'($signed(ins)) >>> 20;
            3'd1: v = (s * 2048) + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
            3'd2: v = (s * 4096) + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2;
            3'd3: v = longint'($signed(ins & 32'hFFFF_F000));
            3'd4: v = (s * 1048576) + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2;
`ifdef IMM_ZICSR_EN
            3'd5: v = longint'(ins[19:15]);
`endif
            default: e.ill = 1'b1;
        endcase
        e.imm = e.ill ? 64'd0 : 64'(v);
        return e;
    endfunction

    // Advance one cycle: retire last cycle's accept into the model, then drive new inputs.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic ordy);
        @(posedge clk);
        #1;
        if (pend) begin
            q.push_back(pend_e);
            if (pend_e.ill && m_err != (1 << CNT_W) - 1) m_err++;
            pend = 1'b0;
        end
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.imm_src   = src;
        bus.out_ready = ordy;
        if (v && bus.in_ready && !rst) begin
            pend   = 1'b1;
            pend_e = ref_imm(ins, src);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b1, 32'hFFF00093, 3'd6, 1'b0);
        @(posedge clk);
        #1;
        q.delete();
        pend  = 1'b0;
        m_err = 0;
        rst   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
            chk("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
            chk("err_cnt",   64'(bus.err_cnt),   64'(m_err));
            if (q.size() != 0) begin
                chk("imm",         bus.imm,              q[0].imm);
                chk("imm_illegal", 64'(bus.imm_illegal), 64'(q[0].ill));
                if (bus.out_ready) void'(q.pop_front());
            end else begin
                chk("imm_idle",         bus.imm,              64'd0);
                chk("imm_illegal_idle", 64'(bus.imm_illegal), 64'd0);
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.imm_src   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        cyc(1'b0, 0, 0, 1'b0);

        // Single entries, consumer always ready
        cyc(1'b1, 32'hFFF00093, 3'd0, 1'b1);
        cyc(1'b1, 32'h8000006F, 3'd4, 1'b1);
        cyc(1'b1, 32'h800000B7, 3'd3, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);

        // Stall: B then S fill the FIFO, a third push is refused
        cyc(1'b1, 32'hFE000EE3, 3'd2, 1'b0);
        cyc(1'b1, 32'h80A12623, 3'd1, 1'b0);
        cyc(1'b1, 32'h12345678, 3'd0, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);

        // Streaming at count 1
        cyc(1'b1, $urandom, 3'd0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, $urandom, 3'($urandom_range(0, 4)), 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);

        // Illegal formats: counter saturates at 3, then Z/illegal 101
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 3'd6, 1'b1);
        cyc(1'b1, 32'h000FA073, 3'd5, 1'b1);
        cyc(1'b1, 32'h000FA073, 3'd7, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);

        // Reset with the FIFO full
        do_reset();
        cyc(1'b1, 32'hABCDE000, 3'd6, 1'b0);
        cyc(1'b1, 32'h00000013, 3'd7, 1'b0);
        cyc(1'b0, 0, 0, 1'b0);
        do_reset();
        cyc(1'b0, 0, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom), $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));

        // Drain with a bounded budget
        for (int i = 0; i < 20 && (q.size() != 0 || pend); i++) cyc(1'b0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 1'b1);
        n_chk++;
        if (q.size() != 0 || pend) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        @(negedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
